// File: rtl/note_display_pkg.sv
// Shared definitions for the note display path: note codes, octave type,
// screen geometry, sequencer state encoding and slot geometry helper.
package note_display_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_A    = 4'd1;
  localparam logic [3:0] NOTE_AS   = 4'd2;
  localparam logic [3:0] NOTE_B    = 4'd3;
  localparam logic [3:0] NOTE_C    = 4'd4;
  localparam logic [3:0] NOTE_CS   = 4'd5;
  localparam logic [3:0] NOTE_D    = 4'd6;
  localparam logic [3:0] NOTE_DS   = 4'd7;
  localparam logic [3:0] NOTE_E    = 4'd8;
  localparam logic [3:0] NOTE_F    = 4'd9;
  localparam logic [3:0] NOTE_FS   = 4'd10;
  localparam logic [3:0] NOTE_G    = 4'd11;
  localparam logic [3:0] NOTE_GS   = 4'd12;

  typedef logic [1:0] octave_t;

  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned GLYPH_PITCH = 12;
  localparam int unsigned EVT_W       = 6;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_INIT_REQ,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_ERASE,
    ST_ERASE_WAIT,
    ST_DRAW,
    ST_DRAW_WAIT
  } slot_state_e;

  function automatic logic [7:0] slot_x(input int unsigned base,
                                        input int unsigned pitch,
                                        input logic [2:0]  idx);
    return 8'(base) + 8'(idx) * 8'(pitch);
  endfunction

  function automatic logic note_code_valid(input logic [3:0] code);
    return (code >= NOTE_A) && (code <= NOTE_GS);
  endfunction

endpackage

// File: rtl/note_event_fifo.sv
// Small synchronous FIFO buffering played-note events (note code + octave).
module note_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/note_slot_ctrl.sv
// Sequencer feeding the note glyph drawer: blanks every slot after reset, then
// places each buffered note in the next slot of the row, erasing it first if occupied.
module note_slot_ctrl
  import note_display_pkg::*;
#(
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned X_BASE     = 4,
  parameter int unsigned SLOT_W     = 38,
  parameter int unsigned Y_ROW      = 50,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       note_valid,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  output logic       note_ready,
  output logic       note_dropped,
  output logic       draw_req,
  input  logic       draw_done,
  output logic       draw_erase,
  output logic [3:0] draw_note,
  output logic [1:0] draw_octave,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic       busy
);

  if (SLOTS < 2 || SLOTS > 8) begin : g_bad_slots
    $error("note_slot_ctrl: SLOTS must be 2..8");
  end
  if (X_BASE + SLOTS * SLOT_W > SCREEN_W) begin : g_bad_row
    $error("note_slot_ctrl: slot row exceeds screen width");
  end
  if (Y_ROW > SCREEN_H - GLYPH_PITCH) begin : g_bad_y
    $error("note_slot_ctrl: Y_ROW too low on screen");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("note_slot_ctrl: FIFO_DEPTH must be a power of 2");
  end

  slot_state_e state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic [2:0]  init_q, init_d;
  logic [7:0]  occ_q, occ_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [3:0]  note_q, note_d;
  octave_t     oct_q, oct_d;
  logic        erase_q, erase_d;
  logic        dropped_q;
  logic        avail_q;

  logic             fifo_push;
  logic             fifo_pop;
  logic [EVT_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             in_init;

  assign in_init    = (state_q == ST_INIT) || (state_q == ST_INIT_REQ) || (state_q == ST_INIT_WAIT);
  assign note_ready = !fifo_full && !in_init;
  assign accept     = note_valid && note_ready;
  assign fifo_push  = accept && note_code_valid(note_in);

  note_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  ({note_in, octave_in}),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    init_d   = init_q;
    occ_d    = occ_q;
    x_d      = x_q;
    y_d      = y_q;
    note_d   = note_q;
    oct_d    = oct_q;
    erase_d  = erase_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_INIT: begin
        x_d     = slot_x(X_BASE, SLOT_W, init_q);
        y_d     = 7'(Y_ROW);
        erase_d = 1'b1;
        state_d = ST_INIT_REQ;
      end
      ST_INIT_REQ: state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (draw_done) begin
          if (init_q == 3'(SLOTS - 1)) begin
            init_d  = '0;
            state_d = ST_IDLE;
          end else begin
            init_d  = init_q + 3'd1;
            state_d = ST_INIT;
          end
        end
      end
      ST_IDLE: begin
        // avail_q holds off the pop until the entry has sat in the FIFO for a full cycle
        if (avail_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          note_d   = fifo_dout[5:2];
          oct_d    = fifo_dout[1:0];
          x_d      = slot_x(X_BASE, SLOT_W, slot_q);
          y_d      = 7'(Y_ROW);
          erase_d  = occ_q[slot_q];
          state_d  = occ_q[slot_q] ? ST_ERASE : ST_DRAW;
        end
      end
      ST_ERASE: state_d = ST_ERASE_WAIT;
      ST_ERASE_WAIT: begin
        if (draw_done) begin
          erase_d = 1'b0;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: state_d = ST_DRAW_WAIT;
      ST_DRAW_WAIT: begin
        if (draw_done) begin
          occ_d[slot_q] = 1'b1;
          slot_d        = (slot_q == 3'(SLOTS - 1)) ? '0 : slot_q + 3'd1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      slot_q    <= '0;
      init_q    <= '0;
      occ_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      note_q    <= '0;
      oct_q     <= '0;
      erase_q   <= 1'b0;
      dropped_q <= 1'b0;
      avail_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      init_q    <= init_d;
      occ_q     <= occ_d;
      x_q       <= x_d;
      y_q       <= y_d;
      note_q    <= note_d;
      oct_q     <= oct_d;
      erase_q   <= erase_d;
      dropped_q <= accept && !note_code_valid(note_in);
      avail_q   <= !fifo_empty;
    end
  end

  assign draw_req     = (state_q == ST_INIT_REQ) || (state_q == ST_ERASE) || (state_q == ST_DRAW);
  assign draw_erase   = erase_q;
  assign draw_note    = note_q;
  assign draw_octave  = oct_q;
  assign draw_x       = x_q;
  assign draw_y       = y_q;
  assign note_dropped = dropped_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_note_slot_ctrl.sv
// Scoreboard bench for note_slot_ctrl: a slot/occupancy reference model predicts
// every drawer request and drop pulse; a monitor pops and compares them.
module tb_note_slot_ctrl;

  localparam int SLOTS      = 4;
  localparam int X_BASE     = 4;
  localparam int SLOT_W     = 38;
  localparam int Y_ROW      = 50;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       note_valid = 1'b0;
  logic [3:0] note_in = '0;
  logic [1:0] octave_in = '0;
  logic       note_ready, note_dropped, draw_req, draw_erase, busy;
  logic       draw_done = 1'b0;
  logic [3:0] draw_note;
  logic [1:0] draw_octave;
  logic [7:0] draw_x;
  logic [6:0] draw_y;

  note_slot_ctrl #(
    .SLOTS(SLOTS), .X_BASE(X_BASE), .SLOT_W(SLOT_W), .Y_ROW(Y_ROW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_in(note_in),
    .octave_in(octave_in), .note_ready(note_ready), .note_dropped(note_dropped),
    .draw_req(draw_req), .draw_done(draw_done), .draw_erase(draw_erase),
    .draw_note(draw_note), .draw_octave(draw_octave), .draw_x(draw_x),
    .draw_y(draw_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit erase;
    int x;
    int note;
    int oct;
    int at_cyc;
    bit init;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];
  bit   occ[SLOTS];
  int   ptr;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_delay = 5;
  int   drop_seen = 0;
  int   erase_seen = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    exp_t e;
    exp_q.delete();
    drop_q.delete();
    ptr = 0;
    for (int s = 0; s < SLOTS; s++) begin
      occ[s]   = 1'b0;
      e.erase  = 1'b1;
      e.x      = X_BASE + s * SLOT_W;
      e.note   = 0;
      e.oct    = 0;
      e.at_cyc = -1;
      e.init   = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void model_accept(input int n, input int o, input int t, input bit lat);
    exp_t e;
    if (n < 1 || n > 12) begin
      drop_q.push_back(t + 1);
      return;
    end
    e.x    = X_BASE + ptr * SLOT_W;
    e.note = n;
    e.oct  = o;
    e.init = 1'b0;
    if (occ[ptr]) begin
      e.erase  = 1'b1;
      e.at_cyc = -1;
      exp_q.push_back(e);
    end
    e.erase  = 1'b0;
    e.at_cyc = lat ? t + 3 : -1;
    exp_q.push_back(e);
    occ[ptr] = 1'b1;
    ptr      = (ptr + 1) % SLOTS;
  endfunction

  // Drawer stand-in: answers each request with draw_done after done_delay cycles (0 = random).
  initial begin
    int pend;
    pend = 0;
    forever begin
      @(posedge clk);
      #1;
      draw_done = 1'b0;
      if (reset) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) draw_done = 1'b1;
      end else if (draw_req) begin
        pend = (done_delay == 0) ? int'($urandom_range(6, 1)) : done_delay;
      end
    end
  end

  initial begin
    exp_t e;
    int   t;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (draw_req) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_req: got req x=%0d erase=%0d, required no request", draw_x, draw_erase);
          end else begin
            e = exp_q.pop_front();
            chk("req_erase", draw_erase, e.erase);
            chk("req_x", draw_x, e.x);
            chk("req_y", draw_y, Y_ROW);
            chk("req_note", draw_note, e.note);
            chk("req_octave", draw_octave, e.oct);
            if (e.at_cyc >= 0) chk("req_latency", cyc, e.at_cyc);
            if (e.init) chk("init_ready_low", note_ready, 0);
            if (draw_erase && !e.init) erase_seen++;
          end
        end
        if (note_dropped) begin
          drop_seen++;
          if (drop_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_drop: got pulse at cycle %0d, required none", cyc);
          end else begin
            t = drop_q.pop_front();
            chk("drop_cycle", cyc, t);
          end
        end
      end
    end
  end

  // Caller is at posedge+1; returns at the next posedge+1 with note_valid low.
  task automatic send(input int n, input int o, input bit lat, output bit stalled);
    int w;
    w          = 0;
    stalled    = 1'b0;
    note_valid = 1'b1;
    note_in    = n[3:0];
    octave_in  = o[1:0];
    forever begin
      @(negedge clk);
      if (note_ready) begin
        model_accept(n, o, cyc, lat);
        break;
      end
      stalled = 1'b1;
      w++;
      if (w > 400) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got note_ready=0 for %0d cycles, required acceptance", w);
        break;
      end
    end
    @(posedge clk);
    #1;
    note_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    note_valid = 1'b0;
    #1;
    chk("rst_note_ready", note_ready, 0);
    chk("rst_note_dropped", note_dropped, 0);
    chk("rst_draw_req", draw_req, 0);
    chk("rst_draw_erase", draw_erase, 0);
    chk("rst_draw_note", draw_note, 0);
    chk("rst_draw_octave", draw_octave, 0);
    chk("rst_draw_x", draw_x, 0);
    chk("rst_draw_y", draw_y, 0);
    chk("rst_busy", busy, 1);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int w;
    w = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0 || drop_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_pending_reqs"}, exp_q.size(), 0);
    chk({nm, "_pending_drops"}, drop_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    int k, d0, e0, w;
    int t3[5];
    t3 = '{1, 3, 4, 6, 8};

    // Reset and the INIT blanking sequence.
    done_delay = 5;
    do_reset();
    wait_idle("t1");
    chk("t1_ready_after_init", note_ready, 1);

    // Single event: latency, then pointer advanced to slot 1.
    send(5, 2, 1'b1, st);
    wait_idle("t2");
    send(7, 1, 1'b0, st);
    wait_idle("t2b");

    // Five events from slot 0: the fifth reuses slot 0 with an erase first.
    do_reset();
    wait_idle("t3_init");
    e0 = erase_seen;
    for (int i = 0; i < 5; i++) send(t3[i], i % 4, 1'b0, st);
    wait_idle("t3");
    chk("t3_erase_count", erase_seen - e0, 1);

    // Burst with the drawer stalled: four buffered plus one in service.
    done_delay = 40;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      send(int'($urandom_range(12, 1)), int'($urandom_range(3, 0)), 1'b0, st);
      if (!st) k++;
    end
    chk("t4_unstalled_accepts", k, 5);
    chk("t4_sixth_stalled", st, 1);
    done_delay = 0;
    wait_idle("t4");

    // Invalid codes are accepted and dropped.
    d0 = drop_seen;
    send(0, 1, 1'b0, st);
    send(14, 2, 1'b0, st);
    wait_idle("t5");
    chk("t5_drop_count", drop_seen - d0, 2);

    // Randomised traffic with random drawer latency.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(3, 0)) begin
        @(posedge clk);
        #1;
      end
      send(int'($urandom_range(15, 0)), int'($urandom_range(3, 0)), 1'b0, st);
    end
    wait_idle("rand");

    // Reset while waiting on an erase: FIFO flushed, INIT restarts from slot 0.
    do_reset();
    wait_idle("t6_init");
    done_delay = 4;
    e0 = erase_seen;
    for (int i = 0; i < SLOTS + 2; i++) send(int'($urandom_range(12, 1)), 0, 1'b0, st);
    w = 0;
    while (erase_seen == e0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("t6_erase_reached", erase_seen - e0, 1);
    #2;
    do_reset();
    wait_idle("t6");
    done_delay = 0;
    send(9, 3, 1'b1, st);
    wait_idle("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
